// File: rtl/uart_prog_loader.sv
// uart_prog_loader: sequences a programming session from the UART receiver into
// instruction memory. Sets the receiver baud divisor, holds the core in reset,
// packs received bytes little-endian into 32-bit words and writes them to
// consecutive word addresses over a req/gnt port. Ends on a terminator word or
// at the last address, then releases the core.
//
// Ports:
//   i_Clock, rst_ni      clock, async active-low reset
//   i_prog_en            level; rising edge starts programming, low aborts/finishes
//   i_cpb                requested clocks-per-bit for the receiver
//   i_rx_dv, i_rx_byte   byte-valid pulse and byte from the UART receiver
//   o_clks_per_bit       divisor driven to the UART receiver
//   o_mem_req/addr/wdata memory write request, word address, write data
//   i_mem_gnt            write accepted this cycle
//   o_core_rst_n         core reset, active-low
//   o_busy, o_done       programming in progress / complete
//   o_overrun            sticky byte-loss flag
module uart_prog_loader #(
    parameter int unsigned ADDR_W      = 14,
    parameter logic [31:0] END_WORD    = 32'h0000_0FFF,
    parameter logic [15:0] DEFAULT_CPB = 16'd868
) (
    input  logic              i_Clock,
    input  logic              rst_ni,
    input  logic              i_prog_en,
    input  logic [15:0]       i_cpb,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_byte,
    output logic [15:0]       o_clks_per_bit,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_gnt,
    output logic              o_core_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun
);

    typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

    state_e            state_q;
    logic              prog_en_q;
    logic              prog_prev_q;
    logic [1:0]        cnt_q;
    logic [7:0]        skid_q;
    logic              skid_full_q;
    logic [15:0]       cpb_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              core_rst_n_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    logic prog_rise;
    logic last_word;

    assign prog_rise = prog_en_q & ~prog_prev_q;
    assign last_word = (wdata_q == END_WORD) || (addr_q == {ADDR_W{1'b1}});

    always_ff @(posedge i_Clock or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            prog_en_q    <= 1'b0;
            prog_prev_q  <= 1'b0;
            cnt_q        <= 2'd0;
            skid_q       <= 8'd0;
            skid_full_q  <= 1'b0;
            cpb_q        <= DEFAULT_CPB;
            req_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            core_rst_n_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            prog_en_q   <= i_prog_en;
            prog_prev_q <= prog_en_q;

            case (state_q)
                StIdle: begin
                    if (prog_rise) begin
                        cpb_q        <= (i_cpb < 16'd2) ? DEFAULT_CPB : i_cpb;
                        addr_q       <= '0;
                        cnt_q        <= 2'd0;
                        skid_full_q  <= 1'b0;
                        overrun_q    <= 1'b0;
                        core_rst_n_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= StRecv;
                    end
                end

                StRecv: begin
                    if (!prog_en_q) begin
                        // Abort: partial word and skid byte are dropped.
                        state_q      <= StIdle;
                        busy_q       <= 1'b0;
                        core_rst_n_q <= 1'b1;
                        skid_full_q  <= 1'b0;
                        cnt_q        <= 2'd0;
                    end else if (skid_full_q) begin
                        // Byte caught during the previous write becomes byte 0.
                        wdata_q[7:0] <= skid_q;
                        skid_full_q  <= 1'b0;
                        if (i_rx_dv) begin
                            wdata_q[15:8] <= i_rx_byte;
                            cnt_q         <= 2'd2;
                        end else begin
                            cnt_q <= 2'd1;
                        end
                    end else if (i_rx_dv) begin
                        wdata_q[8*cnt_q +: 8] <= i_rx_byte;
                        cnt_q                 <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= StWrite;
                            req_q   <= 1'b1;
                        end
                    end
                end

                StWrite: begin
                    if (i_rx_dv) begin
                        if (skid_full_q) begin
                            overrun_q <= 1'b1;
                        end else begin
                            skid_q      <= i_rx_byte;
                            skid_full_q <= 1'b1;
                        end
                    end
                    // Request is held until granted, even when aborting.
                    if (i_mem_gnt) begin
                        req_q <= 1'b0;
                        cnt_q <= 2'd0;
                        if (!prog_en_q) begin
                            state_q      <= StIdle;
                            busy_q       <= 1'b0;
                            core_rst_n_q <= 1'b1;
                            skid_full_q  <= 1'b0;
                        end else if (last_word) begin
                            state_q      <= StDone;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                        end else begin
                            addr_q  <= addr_q + ADDR_W'(1);
                            state_q <= StRecv;
                        end
                    end
                end

                StDone: begin
                    if (!prog_en_q) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_clks_per_bit = cpb_q;
    assign o_mem_req      = req_q;
    assign o_mem_addr     = addr_q;
    assign o_mem_wdata    = wdata_q;
    assign o_core_rst_n   = core_rst_n_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_overrun      = overrun_q;

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Sequencer that sits between the programming UART receiver and instruction memory.
- Sets the receiver's baud divisor and holds the core in reset while programming.
- Assembles received bytes into little-endian 32-bit words and writes them to consecutive word addresses through a req/gnt memory port.
- Ends programming on a terminator word or at the top of the address space, then releases the core.

Parameters:
- ADDR_W, 14, width of the word address.
- END_WORD, 32'h0000_0FFF, terminator word. It is written to memory, then programming ends.
- DEFAULT_CPB, 16'd868, baud divisor used at reset and when i_cpb < 2.

Ports:
- i_Clock  in  1  clock
- rst_ni  in  1  reset
- i_prog_en  in  1  level; rising edge starts programming, low aborts/finishes
- i_cpb  in  16  requested clocks-per-bit
- i_rx_dv  in  1  one-cycle byte-valid pulse from the UART receiver
- i_rx_byte  in  8  received byte, valid with i_rx_dv
- o_clks_per_bit  out  16  divisor driven to the UART receiver
- o_mem_req  out  1  write request
- o_mem_addr  out  ADDR_W  word address
- o_mem_wdata  out  32  write data
- i_mem_gnt  in  1  write accepted this cycle
- o_core_rst_n  out  1  core reset, active-low
- o_busy  out  1  programming in progress
- o_done  out  1  programming complete
- o_overrun  out  1  sticky byte-loss flag

Behaviour:
- Reset: rst_ni is asynchronous, active-low; the clock is i_Clock. All state is cleared. Reset values of outputs:
  - o_clks_per_bit = DEFAULT_CPB.
  - o_core_rst_n = 1 (core runs existing image).
  - o_mem_req, o_busy, o_done, o_overrun = 0.
  - o_mem_addr = 0, o_mem_wdata = 0.
- i_prog_en is registered once internally. The rise is detected as registered value 1 while its previous value is 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - On i_prog_en rise: o_clks_per_bit <= (i_cpb < 2) ? DEFAULT_CPB : i_cpb.
  - Same cycle: addr <= 0, byte count <= 0, o_overrun <= 0, o_core_rst_n <= 0, o_busy <= 1, go to RECV.
  - i_rx_dv is ignored in IDLE.
- RECV:
  - Each i_rx_dv writes i_rx_byte into wdata[8*cnt +: 8]; cnt is 2 bits.
  - The cycle that stores byte 3 moves to WRITE, with o_mem_req = 1 in the next cycle.
  - A byte held in the skid register is consumed first, as byte 0, on the first RECV cycle.
- WRITE:
  - o_mem_req stays high with o_mem_addr and o_mem_wdata stable until i_mem_gnt is sampled high.
  - On gnt, o_mem_req drops the next cycle, and:
    - if wdata == END_WORD, or addr == 2^ADDR_W-1: go to DONE;
    - else addr <= addr+1, cnt <= 0, go to RECV.
  - Minimum latency: 1 cycle from 4th i_rx_dv to req. With gnt tied high, req lasts exactly 1 cycle.
- Skid buffer:
  - There is one 8-bit holding register.
  - An i_rx_dv during WRITE is stored there if it is empty.
  - If it is already full, the byte is dropped and o_overrun <= 1. o_overrun is sticky until the next programming start.
- DONE:
  - o_busy = 0, o_done = 1, o_core_rst_n = 1.
  - i_rx_dv is ignored.
  - i_prog_en low: go to IDLE, o_done <= 0.
- Abort:
  - i_prog_en low in RECV: go to IDLE next cycle. The partial word and skid byte are discarded; o_busy = 0, o_core_rst_n = 1, o_done stays 0.
  - i_prog_en low in WRITE: the pending write completes through gnt first, then go to IDLE. req is never withdrawn without gnt.
- Simultaneous events:
  - gnt and i_rx_dv in the same cycle: the byte goes to the skid register.
  - i_prog_en rise is ignored outside IDLE.
- o_clks_per_bit changes only on a programming start; it holds its value through DONE/IDLE.

Test Plan:
- Reset, then i_prog_en=1 with i_cpb=16'd20 -> o_clks_per_bit=20, o_core_rst_n=0, o_busy=1. Repeat with i_cpb=1 -> 868.
- Bytes 78 56 34 12, gnt tied 1 -> one-cycle req, addr 0, wdata 32'h12345678. Next word goes to addr 1.
- Bytes FF 0F 00 00 -> write of 32'h00000FFF, then o_done=1, o_core_rst_n=1, o_busy=0. Dropping i_prog_en gives o_done=0.
- gnt held low 50 cycles while 2 bytes arrive -> req and addr/data stable, 1st byte buffered and used as byte 0, o_overrun=1 after 2nd.
- ADDR_W=2, non-terminator words -> 4 writes to addr 0..3, then DONE with no addr wrap.
- i_prog_en dropped after 2 bytes -> IDLE, no req, core released. Restart gives addr 0 and a fresh word.
